// File: rtl/kmean_mul_share_arb_pkg.sv
// Shared widths and helpers for the kmeans shared-multiplier group.
package kmean_mul_pkg;

  localparam int unsigned A_W = 7;
  localparam int unsigned B_W = 10;
  localparam int unsigned P_W = 17;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/kmean_mul_share_arb_if.sv
// Requester/result bus for the shared multiplier; slave is the arbiter side.
interface kmean_mul_share_arb_if
  import kmean_mul_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 32
);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_W-1:0]       out_data;
  logic [ID_W-1:0]      out_id;
  logic [CNT_W-1:0]     op_count;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_id, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_id, op_count
  );

endinterface

// File: rtl/kmean_mul_share_arb_pipe.sv
// NUM_STAGE-deep multiply pipe with valid/id sideband; the product is formed
// after the operand register so the DSP input/product registers can absorb it.
module kmean_mul_pipe
  import kmean_mul_pkg::*;
#(
  parameter int unsigned NUM_STAGE = 2,
  parameter int unsigned ID_W      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic [A_W-1:0]  in_a,
  input  logic [B_W-1:0]  in_b,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [P_W-1:0]  out_p,
  output logic [ID_W-1:0] out_id
);

  logic [NUM_STAGE-1:0] v_q, v_d;
  logic [ID_W-1:0]      id_q [NUM_STAGE];
  logic [ID_W-1:0]      id_d [NUM_STAGE];
  logic [A_W-1:0]       a_q, a_d;
  logic [B_W-1:0]       b_q, b_d;
  logic [P_W-1:0]       prod;

  assign prod = P_W'(a_q) * P_W'(b_q);

  always_comb begin
    v_d  = v_q;
    id_d = id_q;
    a_d  = a_q;
    b_d  = b_q;
    if (en) begin
      v_d[0]  = in_valid;
      id_d[0] = in_id;
      a_d     = in_a;
      b_d     = in_b;
      for (int unsigned k = 1; k < NUM_STAGE; k++) begin
        v_d[k]  = v_q[k-1];
        id_d[k] = id_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      id_q <= '{default: '0};
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      v_q  <= v_d;
      id_q <= id_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  assign out_valid = v_q[NUM_STAGE-1];
  assign out_id    = id_q[NUM_STAGE-1];

  generate
    if (NUM_STAGE == 1) begin : g_comb_p
      assign out_p = prod;
    end else begin : g_reg_p
      logic [P_W-1:0] p_q [NUM_STAGE-1];
      logic [P_W-1:0] p_d [NUM_STAGE-1];

      always_comb begin
        p_d = p_q;
        if (en) begin
          p_d[0] = prod;
          for (int unsigned k = 1; k < NUM_STAGE - 1; k++) p_d[k] = p_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) p_q <= '{default: '0};
        else     p_q <= p_d;
      end

      assign out_p = p_q[NUM_STAGE-2];
    end
  endgenerate

endmodule

// File: rtl/kmean_mul_share_arb.sv
// Round-robin share of one 7x10 multiplier among N_REQ distance lanes;
// results come back in acceptance order tagged with the requester id.
module kmean_mul_share_arb
  import kmean_mul_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ID_W      = clog2(N_REQ),
  parameter int unsigned NUM_STAGE = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  kmean_mul_share_arb_if.slave   bus
);

  logic [ID_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_found;
  logic             advance;
  logic             fire;
  logic [N_REQ-1:0] ready;
  logic [A_W-1:0]   op_a;
  logic [B_W-1:0]   op_b;
  logic             pipe_valid;
  logic [P_W-1:0]   pipe_p;
  logic [ID_W-1:0]  pipe_id;
  int unsigned      idx;

  // The whole pipe moves together; nothing is accepted while it is frozen.
  assign advance = bus.out_ready | ~pipe_valid;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (k + rr_q) % N_REQ;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
    fire  = gnt_found & advance & ~ap_rst;
    ready = '0;
    if (fire) ready[gnt_id] = 1'b1;
    rr_d       = fire ? ID_W'((gnt_id + 1) % N_REQ) : rr_q;
    op_count_d = op_count_q + CNT_W'(fire);
    op_a       = bus.req_a[gnt_id*A_W +: A_W];
    op_b       = bus.req_b[gnt_id*B_W +: B_W];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_q       <= '0;
      op_count_q <= '0;
    end else begin
      rr_q       <= rr_d;
      op_count_q <= op_count_d;
    end
  end

  kmean_mul_pipe #(
    .NUM_STAGE (NUM_STAGE),
    .ID_W      (ID_W)
  ) u_pipe (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .en        (advance),
    .in_valid  (fire),
    .in_a      (op_a),
    .in_b      (op_b),
    .in_id     (gnt_id),
    .out_valid (pipe_valid),
    .out_p     (pipe_p),
    .out_id    (pipe_id)
  );

  assign bus.req_ready = ready;
  assign bus.out_valid = pipe_valid;
  assign bus.out_data  = pipe_p;
  assign bus.out_id    = pipe_id;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_kmean_mul_share_arb.sv
// Randomized scoreboard bench for the shared multiplier arbiter.
module tb_kmean_mul_share_arb;
  import kmean_mul_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned NS      = 2;
  localparam int unsigned SMALL_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  kmean_mul_share_arb_if #(.N_REQ(N), .ID_W(IDW), .CNT_W(32))      bus ();
  kmean_mul_share_arb_if #(.N_REQ(N), .ID_W(IDW), .CNT_W(SMALL_W)) bus_s ();

  kmean_mul_share_arb #(.N_REQ(N), .ID_W(IDW), .NUM_STAGE(NS), .CNT_W(32)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  // Narrow-counter copy sees identical traffic so the counter wrap is reachable.
  kmean_mul_share_arb #(.N_REQ(N), .ID_W(IDW), .NUM_STAGE(NS), .CNT_W(SMALL_W)) dut_s (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus_s)
  );

  assign bus_s.req_valid = bus.req_valid;
  assign bus_s.req_a     = bus.req_a;
  assign bus_s.req_b     = bus.req_b;
  assign bus_s.out_ready = bus.out_ready;

  typedef struct {
    int unsigned id;
    int unsigned prod;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned ptr   = 0;
  int unsigned cnt   = 0;
  bit          busy [NS];
  bit          prev_rst = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who should win this cycle and what it should produce.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit           adv, gnt;
    int unsigned  g, a, b;
    exp_rdy = '0;
    gnt     = 1'b0;
    g       = 0;
    if (rst) begin
      chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
      ptr = 0;
      cnt = 0;
      foreach (busy[k]) busy[k] = 1'b0;
      sb.delete();
    end else begin
      if (prev_rst) begin
        chk("reset_out_data", 64'(bus.out_data), 64'(0));
        chk("reset_out_id", 64'(bus.out_id), 64'(0));
      end
      chk("out_valid", 64'(bus.out_valid), 64'(busy[NS-1]));
      chk("op_count", 64'(bus.op_count), 64'(cnt));
      chk("op_count_wrap", 64'(bus_s.op_count), 64'(cnt % (1 << SMALL_W)));
      adv = bus.out_ready || !busy[NS-1];
      if (adv) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (!gnt && bus.req_valid[(ptr + k) % N]) begin
            gnt = 1'b1;
            g   = (ptr + k) % N;
          end
        end
      end
      if (gnt) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (gnt) begin
        a = 32'(bus.req_a[g*A_W +: A_W]);
        b = 32'(bus.req_b[g*B_W +: B_W]);
        sb.push_back('{id: g, prod: a * b});
        cnt++;
        ptr = (g + 1) % N;
      end
      if (adv) begin
        for (int k = NS - 1; k > 0; k--) busy[k] = busy[k-1];
        busy[0] = gnt;
      end
    end
    prev_rst = rst;
  end

  logic           hold_v = 1'b0;
  logic [P_W-1:0] hold_d;
  logic [IDW-1:0] hold_i;

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_data", 64'(bus.out_data), 64'(hold_d));
        chk("hold_id", 64'(bus.out_id), 64'(hold_i));
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: id %0d data %0d with nothing outstanding", bus.out_id, bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.prod));
          chk("out_id", 64'(bus.out_id), 64'(e.id));
        end
      end
      hold_v = (bus.out_valid === 1'b1) && !bus.out_ready;
      hold_d = bus.out_data;
      hold_i = bus.out_id;
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int unsigned i, input int unsigned a, input int unsigned b);
    bus.req_a[i*A_W +: A_W] = A_W'(a);
    bus.req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  task automatic rand_ops();
    for (int unsigned i = 0; i < N; i++) begin
      case ($urandom_range(0, 7))
        0:       set_op(i, 127, 1023);
        1:       set_op(i, 0, $urandom_range(0, 1023));
        default: set_op(i, $urandom_range(0, 127), $urandom_range(0, 1023));
      endcase
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    cyc(3);
    rst = 1'b0;

    // single op from requester 0
    set_op(0, 5, 7);
    bus.req_valid = 4'b0001;
    cyc(1);
    bus.req_valid = '0;
    cyc(4);

    // operand extremes on requesters 2 and 3
    set_op(2, 127, 1023);
    set_op(3, 0, 1023);
    bus.req_valid = 4'b1100;
    cyc(2);
    bus.req_valid = '0;
    cyc(3);

    // everyone requesting: strict rotation
    bus.req_valid = '1;
    repeat (16) begin
      rand_ops();
      cyc(1);
    end

    // backpressure with a full pipe
    bus.out_ready = 1'b0;
    cyc(5);
    bus.out_ready = 1'b1;
    cyc(2);
    bus.req_valid = '0;
    cyc(3);

    // reset with two ops in flight, pointer away from 0
    rand_ops();
    bus.req_valid = 4'b0110;
    cyc(2);
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_valid = '1;
    rand_ops();
    cyc(3);
    bus.req_valid = '0;
    cyc(3);

    // random traffic and backpressure
    repeat (400) begin
      bus.req_valid = N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      cyc(1);
    end

    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1);
    chk("drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
